// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan channel selector.
package mux_scan_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width helper that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter for scan mode: counts 0..PERIOD-1 and flags the wrap cycle.
module scan_timer
  import mux_scan_pkg::*;
#(
  parameter  int PERIOD = 5000000,
  localparam int CW     = clog2_min1(PERIOD)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  input  logic hold,
  output logic wrap
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_cur;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_cur = restart ? '0 : cnt_q;
    cnt_d   = cnt_cur;
    wrap    = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (!hold) begin
      if (cnt_cur == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_cur + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select or timed round-robin scan.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int W      = 1,
  parameter  int PERIOD = 5000000,
  localparam int SW     = clog2_min1(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] a,
  input  logic [SW-1:0]    s,
  input  logic             mode,
  input  logic             hold,
  output logic [W-1:0]     y,
  output logic [SW-1:0]    ch,
  output logic             tick
);

  localparam logic [SW-1:0] LAST_CH = SW'(NCH - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   ch_q, ch_d;
  logic [W-1:0]    y_q;
  logic            tick_q;
  logic            wrap;
  logic            s_in_range;
  logic [W-1:0]    chan [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan[k] = a[k*W +: W];
  end

  if (NCH == (1 << SW)) begin : g_full_sel
    assign s_in_range = 1'b1;
  end else begin : g_part_sel
    assign s_in_range = (s < SW'(NCH));
  end

  // Decisions follow the state being entered, so a mode change acts on the same edge.
  scan_timer #(.PERIOD(PERIOD)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_d == SCAN),
    .restart (state_q != SCAN),
    .hold    (hold),
    .wrap    (wrap)
  );

  always_comb begin
    state_d = (mode == MODE_SCAN) ? SCAN : MANUAL;
    ch_d    = ch_q;
    if (state_d == MANUAL) begin
      if (s_in_range) ch_d = s;
    end else if (wrap) begin
      ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MANUAL;
      ch_q    <= '0;
      y_q     <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      y_q     <= chan[ch_d];
      tick_q  <= wrap;
    end
  end

  assign y    = y_q;
  assign ch   = ch_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three configurations share stimulus and are checked against a model.
`timescale 1ns/1ps
module tb_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a;
  logic [1:0]  s;
  logic        mode;
  logic        hold;
  logic        cmp_en;

  logic [2:0][7:0] y_o;
  logic [2:0][1:0] ch_o;
  logic [2:0]      tick_o;

  int checks = 0;
  int errors = 0;

  // Instance 0: NCH=4 PERIOD=3, instance 1: NCH=3 PERIOD=3, instance 2: NCH=4 PERIOD=1.
  localparam int NCH_C [3] = '{4, 3, 4};
  localparam int PER_C [3] = '{3, 3, 1};

  mux_scan #(.NCH(4), .W(8), .PERIOD(3)) dut0 (
    .clk(clk), .rst(rst), .a(a), .s(s), .mode(mode), .hold(hold),
    .y(y_o[0]), .ch(ch_o[0]), .tick(tick_o[0])
  );

  mux_scan #(.NCH(3), .W(8), .PERIOD(3)) dut1 (
    .clk(clk), .rst(rst), .a(a[23:0]), .s(s), .mode(mode), .hold(hold),
    .y(y_o[1]), .ch(ch_o[1]), .tick(tick_o[1])
  );

  mux_scan #(.NCH(4), .W(8), .PERIOD(1)) dut2 (
    .clk(clk), .rst(rst), .a(a), .s(s), .mode(mode), .hold(hold),
    .y(y_o[2]), .ch(ch_o[2]), .tick(tick_o[2])
  );

  // Model: channel index plus the number of dwell cycles already spent on it.
  typedef struct {
    int         ch;
    int         dwell;
    logic [7:0] y;
    bit         tick;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t model_step(input mstate_t st, input int n, input int per,
                                         input logic [31:0] a_v, input int s_v,
                                         input logic mode_v, input logic hold_v);
    mstate_t r = st;
    r.tick = 1'b0;
    if (mode_v) begin
      if (!hold_v) begin
        r.dwell = st.dwell + 1;
        if (r.dwell == per) begin
          r.dwell = 0;
          r.ch    = (st.ch + 1) % n;
          r.tick  = 1'b1;
        end
      end
    end else begin
      r.dwell = 0;
      if (s_v < n) r.ch = s_v;
    end
    r.y = a_v[r.ch*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) m[i] <= '{ch: 0, dwell: 0, y: 8'h00, tick: 1'b0};
      else      m[i] <= model_step(m[i], NCH_C[i], PER_C[i], a, int'(s), mode, hold);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_y%0d", i),    32'(y_o[i]),    32'(m[i].y));
        check($sformatf("model_ch%0d", i),   32'(ch_o[i]),   32'(m[i].ch));
        check($sformatf("model_tick%0d", i), 32'(tick_o[i]), 32'(m[i].tick));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  initial begin
    rst    = 1'b1;
    a      = '0;
    s      = '0;
    mode   = 1'b0;
    hold   = 1'b0;
    cmp_en = 1'b0;
    #1 rst = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_y%0d", i),    32'(y_o[i]),    32'h0);
      check($sformatf("reset_ch%0d", i),   32'(ch_o[i]),   32'h0);
      check($sformatf("reset_tick%0d", i), 32'(tick_o[i]), 32'h0);
    end
    cmp_en = 1'b1;

    // Release into manual select of channel 2.
    @(posedge clk);
    #1;
    a    = 32'h4433_2211;
    s    = 2'd2;
    mode = 1'b0;
    rst  = 1'b1;
    step();
    check("first_edge_y",    32'(y_o[0]),    32'h33);
    check("first_edge_ch",   32'(ch_o[0]),   32'h2);
    check("first_edge_tick", 32'(tick_o[0]), 32'h0);
    check("first_edge_y_n3", 32'(y_o[1]),    32'h33);

    // Scan sequence from channel 0, including the 3->0 wrap.
    s = 2'd0;
    step();
    mode = 1'b1;
    check("scan_seq_ch[0]", 32'(ch_o[0]), 32'(exp_seq[0]));
    for (int k = 1; k < 13; k++) begin
      step();
      check($sformatf("scan_seq_ch[%0d]", k),   32'(ch_o[0]),   32'(exp_seq[k]));
      check($sformatf("scan_seq_tick[%0d]", k), 32'(tick_o[0]), 32'(k % 3 == 0));
      check($sformatf("p1_ch[%0d]", k),         32'(ch_o[2]),   32'(k % 4));
      check($sformatf("p1_tick[%0d]", k),       32'(tick_o[2]), 32'h1);
    end

    // Hold at cnt=1 for five edges, then two more edges to advance.
    step();
    hold = 1'b1;
    repeat (5) begin
      step();
      check("hold_ch",   32'(ch_o[0]),   32'h0);
      check("hold_tick", 32'(tick_o[0]), 32'h0);
    end
    hold = 1'b0;
    step();
    check("release1_ch",   32'(ch_o[0]),   32'h0);
    check("release1_tick", 32'(tick_o[0]), 32'h0);
    step();
    check("release2_ch",   32'(ch_o[0]),   32'h1);
    check("release2_tick", 32'(tick_o[0]), 32'h1);

    // Manual with an out-of-range select on the 3-channel instance.
    mode = 1'b0;
    s    = 2'd1;
    step();
    check("n3_sel1_ch",     32'(ch_o[1]),   32'h1);
    check("p1_exit_ch",     32'(ch_o[2]),   32'h1);
    check("p1_exit_tick",   32'(tick_o[2]), 32'h0);
    s = 2'd3;
    a = 32'h44AA_5511;
    step();
    check("n3_oor_ch", 32'(ch_o[1]), 32'h1);
    check("n3_oor_y",  32'(y_o[1]),  32'h55);
    s = 2'd0;
    step();
    check("n3_sel0_ch", 32'(ch_o[1]), 32'h0);
    check("n3_sel0_y",  32'(y_o[1]),  32'h11);

    // Asynchronous reset mid-scan at ch=2, cnt=1.
    s = 2'd2;
    step();
    mode = 1'b1;
    step();
    check("pre_rst_ch", 32'(ch_o[0]), 32'h2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_y",    32'(y_o[0]),    32'h0);
    check("async_rst_ch",   32'(ch_o[0]),   32'h0);
    check("async_rst_tick", 32'(tick_o[0]), 32'h0);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("post_rst_ch[%0d]", k),   32'(ch_o[0]),   32'(k == 3));
      check($sformatf("post_rst_tick[%0d]", k), 32'(tick_o[0]), 32'(k == 3));
    end

    // Randomized traffic checked only against the model.
    repeat (3000) begin
      step();
      a    = $urandom;
      s    = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter NCH, default 4, number of input channels; SHALL be >= 2 (power of two not required).
REQ-002 Parameter W, default 1, bits per channel.
REQ-003 Parameter PERIOD, default 5000000, clk cycles per channel in scan mode; SHALL be >= 1.
REQ-004 Derived constant SW = max(1, clog2(NCH)), select width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 a  input  NCH*W  packed channel data; channel k occupies bits [k*W +: W].
REQ-008 s  input  SW  manual channel select.
REQ-009 mode  input  1  0 = manual select, 1 = auto scan.
REQ-010 hold  input  1  1 = freeze scan counter and channel (scan mode only).
REQ-011 y  output  W  registered selected data.
REQ-012 ch  output  SW  registered index of the channel currently driving y.
REQ-013 tick  output  1  one-cycle pulse when scan advances ch.

Function
REQ-014 State machine has two states, MANUAL and SCAN; next state = SCAN when mode=1, else MANUAL, evaluated every cycle.
REQ-015 Each edge computes ch_next; the registers SHALL update as ch <= ch_next and y <= a[ch_next*W +: W], with a sampled at that same edge (latency 1 cycle from a/s to y).
REQ-016 MANUAL: ch_next = s when s < NCH; when s >= NCH, ch_next = ch (out-of-range select ignored).
REQ-017 MANUAL: scan counter held at 0; tick = 0.
REQ-018 SCAN: counter cnt counts 0..PERIOD-1; at cnt = PERIOD-1 with hold=0, cnt wraps to 0, ch_next = (ch = NCH-1) ? 0 : ch+1, tick = 1 in the following cycle.
REQ-019 SCAN with hold=0 and cnt < PERIOD-1: cnt increments, ch_next = ch.
REQ-020 SCAN with hold=1: cnt and ch frozen, tick = 0; y continues tracking a on the frozen channel.
REQ-021 hold SHALL have no effect in MANUAL.
REQ-022 PERIOD = 1: ch advances every cycle while in SCAN and hold=0; tick high continuously.
REQ-023 Entry MANUAL->SCAN: cnt starts at 0 in the first SCAN cycle; scan continues from current ch (no jump to 0).
REQ-024 Exit SCAN->MANUAL: ch_next = s on the first MANUAL edge (REQ-016 applies); cnt cleared.
REQ-025 cnt width SHALL be clog2(PERIOD) bits (minimum 1); no overflow beyond PERIOD-1.
REQ-026 tick SHALL be registered and never high for two consecutive cycles unless PERIOD = 1.

Reset
REQ-027 rst low SHALL immediately force y = 0, ch = 0, tick = 0, cnt = 0, state = MANUAL, independent of clk.
REQ-028 First rising edge after rst deasserts SHALL behave as a normal update per REQ-014..REQ-024.
REQ-029 Reset asserted mid-scan SHALL discard the partial count; no tick on release.

Structure
REQ-030 Shared package holds the state enumeration (MANUAL, SCAN) and the mode encoding constants.
REQ-031 One sub-module, scan_timer, containing cnt and the wrap/tick logic (inputs enable, hold; outputs wrap); channel mux and output registers stay in mux_scan.

Verification (NCH=4, W=8, PERIOD=3 unless stated)
REQ-032 Reset release, mode=0, a=0x44332211, s=2 -> after 1 edge y=0x33, ch=2, tick=0.
REQ-033 mode=1 from ch=0, hold=0, a constant 0x44332211 -> ch sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; tick high in the cycle ch changes; wrap 3->0 verified.
REQ-034 SCAN, hold=1 for 5 cycles at cnt=1 -> ch and tick frozen; after release ch advances exactly 2 cycles later (cnt 1->2->wrap).
REQ-035 NCH=3: mode=0, s=3 with ch=1 -> ch stays 1, y = channel 1 data; s=0 -> ch=0 next edge.
REQ-036 rst pulsed low between edges mid-scan (ch=2, cnt=1) -> y, ch, tick = 0 immediately; after release with mode=1, first advance occurs 3 edges later to ch=1.
REQ-037 PERIOD=1, mode=1 -> ch increments every edge 0,1,2,3,0; tick constantly 1; mode->0 with s=1 -> ch=1 next edge, tick=0.
